// File: rtl/frontdoor_memory_pkg.sv
// Shared constants for the front-door memory: default geometry and command encoding.
package frontdoor_memory_pkg;

   localparam int WIDTH_DEFAULT = 16;
   localparam int DEPTH_DEFAULT = 64;

   localparam logic CMD_WRITE = 1'b1;
   localparam logic CMD_READ  = 1'b0;

endpackage

// File: rtl/frontdoor_memory_array.sv
// DEPTH x WIDTH register storage with one write port, one registered read port,
// asynchronous clear and an address range check for non-power-of-two depths.
module memory_array #(
   parameter int WIDTH      = 16,
   parameter int DEPTH      = 64,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WIDTH-1:0]      wdata,
   output logic [WIDTH-1:0]      rdata
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_p1;
   logic             in_range;

   // With a power-of-two depth every address decodes to a word.
   if (DEPTH == (2 ** ADDR_WIDTH)) begin : g_full_range
      assign in_range = 1'b1;
   end else begin : g_range_check
      assign in_range = (32'(addr) < 32'(DEPTH));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en && in_range) begin
         mem[addr] <= wdata;
      end
   end

   // Read stage: out-of-range reads return zero rather than stale data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_p1 <= '0;
      end else if (rd_en) begin
         rdata_p1 <= in_range ? mem[addr] : '0;
      end
   end

   assign rdata = rdata_p1;

endmodule

// File: rtl/frontdoor_memory.sv
// Front-door valid/ready request port onto a single-port synchronous RAM.
// One request (write or read) is accepted per clock once ready is up.
module frontdoor_memory
   import frontdoor_memory_pkg::*;
#(
   parameter int WIDTH      = WIDTH_DEFAULT,
   parameter int DEPTH      = DEPTH_DEFAULT,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_i,
   input  logic                  wr_rd_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [WIDTH-1:0]      wdata_i,
   output logic                  ready_o,
   output logic [WIDTH-1:0]      rdata_o
);

   logic ready;
   logic accept;
   logic wr_en;
   logic rd_en;

   // Ready rises on the first edge after reset release and never stalls after that.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ready <= 1'b0;
      end else begin
         ready <= 1'b1;
      end
   end

   assign accept  = valid_i && ready;
   assign wr_en   = accept && (wr_rd_i == CMD_WRITE);
   assign rd_en   = accept && (wr_rd_i == CMD_READ);
   assign ready_o = ready;

   memory_array #(
      .WIDTH      (WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_memory_array (
      .clk   (clk_i),
      .rst_n (rst_i),
      .wr_en (wr_en),
      .rd_en (rd_en),
      .addr  (addr_i),
      .wdata (wdata_i),
      .rdata (rdata_o)
   );

endmodule

// File: tb/tb_frontdoor_memory.sv
// Directed bench for frontdoor_memory: reset behaviour, write/read paths,
// region isolation, back-to-back read-after-write and reset mid-burst.
module tb_frontdoor_memory;

   localparam int WIDTH = 16;
   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic             clk = 1'b0;
   logic             rst_i = 1'b0;
   logic             valid_i = 1'b0;
   logic             wr_rd_i = 1'b0;
   logic [AW-1:0]    addr_i = '0;
   logic [WIDTH-1:0] wdata_i = '0;
   logic             ready_o;
   logic [WIDTH-1:0] rdata_o;

   logic [WIDTH-1:0] model [DEPTH];
   int n_checks = 0;
   int n_pass   = 0;

   frontdoor_memory #(
      .WIDTH      (WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .valid_i (valid_i),
      .wr_rd_i (wr_rd_i),
      .addr_i  (addr_i),
      .wdata_i (wdata_i),
      .ready_o (ready_o),
      .rdata_o (rdata_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Present one request at the falling edge; it is accepted at the next rising edge.
   task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      @(negedge clk);
      valid_i = 1'b1;
      wr_rd_i = wr;
      addr_i  = a;
      wdata_i = d;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      if (wr) model[a] = d;
   endtask

   task automatic read_check(input string tag, input logic [AW-1:0] a);
      issue(1'b0, a, 16'h0);
      check($sformatf("%s[%0d]", tag, a), rdata_o, model[a]);
   endtask

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
   endtask

   initial begin
      logic [WIDTH-1:0] held;
      clear_model();

      // Reset held for two cycles
      repeat (2) @(posedge clk);
      #1;
      check("reset_ready", {15'b0, ready_o}, 16'h0);
      check("reset_rdata", rdata_o, 16'h0);
      @(negedge clk);
      rst_i = 1'b1;
      #1;
      check("release_ready_pre_edge", {15'b0, ready_o}, 16'h0);
      @(posedge clk);
      #1;
      check("release_ready", {15'b0, ready_o}, 16'h1);
      read_check("reset_read", 6'd0);
      read_check("reset_read", 6'd63);

      // Upper quarter only; lower words must stay zero
      for (int i = 48; i < 64; i++) issue(1'b1, AW'(i), WIDTH'(16'hA000 + i * 16'h0101));
      for (int i = 48; i < 64; i++) read_check("quarter_hi", AW'(i));
      for (int i = 0; i < 48; i++) read_check("quarter_lo", AW'(i));

      // Single write then read
      issue(1'b1, 6'd0, 16'h3524);
      read_check("single", 6'd0);
      check("single_value", rdata_o, 16'h3524);

      // A write leaves rdata unchanged; an idle cycle changes nothing
      issue(1'b1, 6'd5, 16'h5A5A);
      check("write_holds_rdata", rdata_o, 16'h3524);
      @(negedge clk);
      valid_i = 1'b0; wr_rd_i = 1'b1; addr_i = 6'd5; wdata_i = 16'hDEAD;
      @(posedge clk);
      #1;
      check("idle_rdata", rdata_o, 16'h3524);
      read_check("idle_no_write", 6'd5);
      check("idle_value", rdata_o, 16'h5A5A);

      // Full sweep with random data
      for (int i = 0; i < DEPTH; i++) issue(1'b1, AW'(i), WIDTH'($urandom));
      for (int i = 0; i < DEPTH; i++) read_check("sweep", AW'(i));

      // Back-to-back write then read of the same address
      for (int i = 0; i < DEPTH; i++) begin
         issue(1'b1, AW'(i), WIDTH'(16'h1234 ^ (i * 16'h0F1)));
         read_check("raw", AW'(i));
      end

      // Reset asserted in the middle of a write burst at address 10
      read_check("pre_reset", 6'd63);
      held = rdata_o;
      issue(1'b1, 6'd10, 16'h1111);
      issue(1'b1, 6'd10, 16'h2222);
      @(negedge clk);
      valid_i = 1'b1; wr_rd_i = 1'b1; addr_i = 6'd10; wdata_i = 16'h3333;
      #2;
      rst_i = 1'b0;
      #1;
      check("midreset_ready", {15'b0, ready_o}, 16'h0);
      check("midreset_rdata", rdata_o, 16'h0);
      if (held == 16'h0) $display("note: pre-reset rdata happened to be zero");
      valid_i = 1'b0;
      clear_model();
      @(posedge clk);
      #1;
      check("midreset_ready_held", {15'b0, ready_o}, 16'h0);
      @(negedge clk);
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      check("midreset_release_ready", {15'b0, ready_o}, 16'h1);
      for (int i = 0; i < DEPTH; i++) read_check("post_reset", AW'(i));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/frontdoor_memory.md
# frontdoor_memory

Single-port synchronous RAM with a valid/ready front-door request interface. One request is accepted per clock, either a write or a read, and read data is returned on a registered output. The block is the addressable storage behind the front-door access path. Testbenches and bus adapters drive it directly with one request per cycle.

## Interface

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 64, number of words.
- ADDR_WIDTH, $clog2(DEPTH), address width in bits.

Ports:
- clk_i  input  1  single clock; all state changes on its rising edge.
- rst_i  input  1  reset; asynchronous, active-low. Asserted when 0.
- valid_i  input  1  request valid.
- wr_rd_i  input  1  request type: 1 = write, 0 = read.
- addr_i  input  ADDR_WIDTH  word address.
- wdata_i  input  WIDTH  write data; ignored for reads.
- ready_o  output  1  block can accept a request.
- rdata_o  output  WIDTH  read data from the last accepted read.

## Operation

- Request acceptance:
  - A request is accepted at a rising edge where valid_i=1 and ready_o=1.
  - Requesters hold valid_i, wr_rd_i, addr_i and wdata_i stable until acceptance.
  - A requester may de-assert valid_i without penalty before acceptance.
- Write: mem[addr_i] <= wdata_i at the accepting edge. rdata_o is unchanged.
- Read: rdata_o <= mem[addr_i] at the accepting edge. rdata_o holds that value until the next accepted read or a reset.
- Out-of-range address (addr_i >= DEPTH, possible only when DEPTH is not a power of two):
  - A write is dropped and storage is unchanged.
  - A read returns all-zero on rdata_o.
  - The request is still accepted (handshake completes).
- Reset (rst_i=0), effective immediately, independent of clk_i:
  - ready_o=0.
  - rdata_o=0.
  - Every storage word cleared to 0.
- After reset:
  - ready_o rises at the first rising edge with rst_i=1.
  - ready_o then stays 1. There are no stall conditions; the block accepts back-to-back requests every cycle.
- valid_i=0 cycles: no state change.

## Timing

- Write latency:
  - Data is stored at the accepting edge.
  - A read of the same address accepted at the very next edge returns the new data (no read-after-write hazard).
- Read latency: 1 cycle. rdata_o is valid immediately after the accepting edge.
- Reset mid-operation:
  - Any request in flight is discarded.
  - Storage is zeroed and ready_o drops in the same delta.
  - After reset release the requester must re-issue the request.
- Reset release:
  - rst_i rising is synchronous-deasserted by the system.
  - The first request can be accepted at the second rising edge after release (the first edge raises ready_o).
- Handshake: ready_o is registered and never depends combinationally on valid_i.

## Structure

- Shared package frontdoor_memory_pkg:
  - Default WIDTH/DEPTH constants.
  - Command encoding constants CMD_WRITE=1'b1 and CMD_READ=1'b0.
- Sub-module memory_array:
  - Storage: DEPTH x WIDTH register array.
  - One write port and one registered read port.
  - Async clear on reset.
  - Range check.
- Top level: handshake/ready register, accept decode, and the instance of memory_array.

## Test plan

- Reset: hold rst_i=0 for 2 cycles, then release.
  - During reset: ready_o=0 and rdata_o=0.
  - After the first edge following release: ready_o=1.
  - Reading addresses 0 and 63 returns 0.
- Single write/read:
  - Write addr 0 = 16'h3524, then read addr 0.
  - rdata_o=16'h3524 one cycle after read acceptance.
- Full sweep:
  - Write addr i = random for i=0..63, then read 0..63.
  - Each rdata_o matches the stored value; addresses 0 and 63 are covered.
- Quarter and half regions:
  - Write/read 48..63 only.
  - Those addresses return written data; addresses 0..47 still read 0.
- Consecutive write-then-read per address, i=0..63, back-to-back:
  - Each read returns the data written the previous cycle.
- Reset mid-stream:
  - Assert rst_i during a write burst at addr 10.
  - ready_o falls immediately and all words read 0 afterwards.
